// File: rtl/axonerve_kvs_rtl_wr_burst_issuer.sv
// Write-side AXI4 AW/B control: splits one transfer into bursts, tracks B credits,
// and hands a burst descriptor to the W-channel formatter on every AW handshake.
module axonerve_kvs_rtl_wr_burst_issuer #(
  parameter int C_ADDR_WIDTH       = 64,
  parameter int C_DATA_WIDTH       = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_BURST_LENGTH = 64,
  parameter int C_MAX_OUTSTANDING  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         ctrl_err,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         wburst_push,
  output logic [7:0]                   wburst_len
);

  localparam int BPB     = C_DATA_WIDTH / 8;
  localparam int LOG2BPB = $clog2(BPB);
  localparam int BW      = C_XFER_SIZE_WIDTH + 1;
  localparam int OW      = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = ~C_ADDR_WIDTH'(BPB - 1);
  localparam logic [C_ADDR_WIDTH-1:0] STRIDE    = C_ADDR_WIDTH'(C_MAX_BURST_LENGTH * BPB);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [BW-1:0]           r_beats_left;
  logic [OW-1:0]           r_outstanding;
  logic                    r_awvalid;
  logic [C_ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]              r_awlen;
  logic                    r_bready;
  logic                    r_done;
  logic                    r_err;

  logic          w_aw_hs;
  logic          w_b_hs;
  logic [OW-1:0] w_out_next;
  logic [BW-1:0] w_beats_req;
  logic [BW-1:0] w_beats_after;
  logic [7:0]    w_next_len;
  logic          w_credit_ok;

  assign w_aw_hs     = r_awvalid & m_axi_awready;
  assign w_b_hs      = m_axi_bvalid & r_bready;
  assign w_out_next  = r_outstanding + OW'(w_aw_hs) - OW'(w_b_hs);
  assign w_credit_ok = w_out_next < OW'(C_MAX_OUTSTANDING);
  // One extra bit keeps size = all-ones from overflowing during the round-up.
  assign w_beats_req   = (BW'(ctrl_xfer_size_in_bytes) + BW'(BPB - 1)) >> LOG2BPB;
  assign w_beats_after = w_aw_hs ? (r_beats_left - (BW'(r_awlen) + BW'(1))) : r_beats_left;
  assign w_next_len    = (w_beats_after > BW'(C_MAX_BURST_LENGTH)) ?
                         8'(C_MAX_BURST_LENGTH - 1) : 8'(w_beats_after - BW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_beats_left  <= '0;
      r_outstanding <= '0;
      r_awvalid     <= 1'b0;
      r_awaddr      <= '0;
      r_awlen       <= '0;
      r_bready      <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_done        <= 1'b0;
      if (w_b_hs && (m_axi_bresp != 2'b00))
        r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ctrl_start) begin
            r_err <= 1'b0;
            if (ctrl_xfer_size_in_bytes == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_awaddr     <= ctrl_addr_offset & ADDR_MASK;
              r_beats_left <= w_beats_req;
              r_bready     <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_aw_hs) begin
            r_beats_left <= w_beats_after;
            r_awaddr     <= r_awaddr + STRIDE;
          end
          // A presented burst stays put until accepted; credits gate only a new assertion.
          if (r_awvalid && !w_aw_hs) begin
            r_awvalid <= 1'b1;
          end else if ((w_beats_after != '0) && w_credit_ok) begin
            r_awvalid <= 1'b1;
            r_awlen   <= w_next_len;
          end else begin
            r_awvalid <= 1'b0;
          end
          if (w_aw_hs && (w_beats_after == '0))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_out_next == '0) begin
            r_state  <= S_DONE;
            r_bready <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_done     = r_done;
  assign ctrl_err      = r_err;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_bready  = r_bready;
  assign wburst_push   = w_aw_hs;
  assign wburst_len    = r_awlen;

endmodule

// File: tb/tb_axonerve_kvs_rtl_wr_burst_issuer.sv
// Self-checking bench for the write burst issuer: randomized transfers scored against
// a burst-list model, plus directed credit, stability, error and reset scenarios.
module tb_axonerve_kvs_rtl_wr_burst_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_start;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic        ctrl_done;
  logic        ctrl_err;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        wburst_push;
  logic [7:0]  wburst_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axonerve_kvs_rtl_wr_burst_issuer dut (
    .clk                     (clk),
    .rst                     (rst),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_done               (ctrl_done),
    .ctrl_err                (ctrl_err),
    .m_axi_awvalid           (m_axi_awvalid),
    .m_axi_awready           (m_axi_awready),
    .m_axi_awaddr            (m_axi_awaddr),
    .m_axi_awlen             (m_axi_awlen),
    .m_axi_bvalid            (m_axi_bvalid),
    .m_axi_bready            (m_axi_bready),
    .m_axi_bresp             (m_axi_bresp),
    .wburst_push             (wburst_push),
    .wburst_len              (wburst_len)
  );

  // Pulses start for one cycle; returns at the negedge after the start edge.
  task automatic kick(input logic [63:0] addr, input logic [31:0] size);
    @(negedge clk);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
  endtask

  // Completes a transfer with always-ready AW and eager B; only counts, never judges.
  task automatic run_out(inout int pending, inout int n_aw, inout int n_b, output bit saw_done);
    saw_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ctrl_done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
      m_axi_awready = 1'b1;
      m_axi_bvalid  = (pending > 0);
      m_axi_bresp   = 2'b00;
      #1;
      if (m_axi_awvalid && m_axi_awready) begin n_aw++; pending++; end
      if (m_axi_bvalid && m_axi_bready)   begin n_b++;  pending--; end
      @(negedge clk);
    end
    m_axi_awready = 1'b0;
    m_axi_bvalid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
    m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    repeat (3) @(negedge clk);
    total++;
    if ({ctrl_done, ctrl_err, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_bready,
         wburst_push, wburst_len} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got done=%b err=%b awv=%b awaddr=%h awlen=%h bready=%b push=%b wlen=%h want all 0",
               ctrl_done, ctrl_err, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_bready, wburst_push, wburst_len);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One transfer scored against the burst list derived from ceil() sizing rules.
  task automatic test_xfer(input string nm, input logic [63:0] addr, input logic [31:0] size,
                           input int rdy_pct, input int bv_pct, input int bad_idx, input int stray_at);
    logic [63:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    logic [63:0] beats, rem, prev_addr, ea;
    logic [7:0]  prev_len, el;
    int          nb, pending, n_aw, n_b, out_model, limit;
    bit          exp_err, saw_done, prev_stall;
    beats = ({32'd0, size} + 64'd63) / 64;
    for (logic [63:0] k = 0; k < (beats + 63) / 64; k++) begin
      exp_addr.push_back((addr & ~64'h3F) + k * 64'd4096);
      rem = beats - k * 64;
      exp_len.push_back(rem >= 64 ? 8'd63 : 8'(rem - 1));
    end
    nb = exp_addr.size();
    pending = 0; n_aw = 0; n_b = 0; out_model = 0;
    exp_err = 1'b0; saw_done = 1'b0; prev_stall = 1'b0;
    prev_addr = '0; prev_len = '0;
    limit = 200 + 40 * nb;
    m_axi_awready = 1'b0; m_axi_bvalid = 1'b0;
    kick(addr, size);
    total++;
    if (ctrl_err !== 1'b0) begin
      bad++; $display("FAIL %s err_clear_on_start: got %b want 0", nm, ctrl_err);
    end
    if (size == 0) begin
      total++;
      if (ctrl_done !== 1'b1 || m_axi_awvalid !== 1'b0) begin
        bad++; $display("FAIL %s zero_size_done: got done=%b awv=%b want done=1 awv=0", nm, ctrl_done, m_axi_awvalid);
      end
      saw_done = 1'b1;
    end else begin
      for (int cyc = 0; cyc < limit; cyc++) begin
        if (ctrl_done === 1'b1) begin
          saw_done = 1'b1;
          total++;
          if (n_aw != nb || n_b != nb || ctrl_err !== exp_err) begin
            bad++;
            $display("FAIL %s done_state: got aw=%0d b=%0d err=%b want aw=%0d b=%0d err=%b",
                     nm, n_aw, n_b, ctrl_err, nb, nb, exp_err);
          end
          break;
        end
        m_axi_awready = ($urandom_range(99) < rdy_pct);
        m_axi_bvalid  = (pending > 0) && ($urandom_range(99) < bv_pct);
        m_axi_bresp   = (m_axi_bvalid && n_b == bad_idx) ? 2'b10 : 2'b00;
        ctrl_start    = (cyc == stray_at);
        if (cyc == stray_at) ctrl_xfer_size_in_bytes = '0;
        #1;
        total++;
        if (m_axi_awvalid && out_model >= 16) begin
          bad++; $display("FAIL %s credit_gate: got awvalid=1 with %0d outstanding want 0", nm, out_model);
        end
        if (prev_stall) begin
          total++;
          if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== prev_addr || m_axi_awlen !== prev_len) begin
            bad++;
            $display("FAIL %s aw_stable: got v=%b a=%h l=%h want v=1 a=%h l=%h",
                     nm, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, prev_addr, prev_len);
          end
        end
        if (m_axi_awvalid && m_axi_awready) begin
          ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : 64'hDEAD;
          el = (exp_len.size() > 0) ? exp_len.pop_front() : 8'hEE;
          total++;
          if (m_axi_awaddr !== ea || m_axi_awlen !== el) begin
            bad++; $display("FAIL %s aw_burst%0d: got a=%h l=%0d want a=%h l=%0d", nm, n_aw, m_axi_awaddr, m_axi_awlen, ea, el);
          end
          total++;
          if (wburst_push !== 1'b1 || wburst_len !== el) begin
            bad++; $display("FAIL %s wburst: got push=%b len=%0d want push=1 len=%0d", nm, wburst_push, wburst_len, el);
          end
          n_aw++; pending++; out_model++;
          prev_stall = 1'b0;
        end else begin
          total++;
          if (wburst_push !== 1'b0) begin
            bad++; $display("FAIL %s wburst_idle: got push=%b want 0", nm, wburst_push);
          end
          prev_stall = m_axi_awvalid;
          prev_addr  = m_axi_awaddr;
          prev_len   = m_axi_awlen;
        end
        if (m_axi_bvalid) begin
          total++;
          if (m_axi_bready !== 1'b1) begin
            bad++; $display("FAIL %s bready: got %b want 1", nm, m_axi_bready);
          end else begin
            if (m_axi_bresp != 2'b00) exp_err = 1'b1;
            n_b++; pending--; out_model--;
          end
        end
        @(negedge clk);
      end
    end
    ctrl_start = 1'b0; m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    if (!saw_done) begin
      total++; bad++;
      $display("FAIL %s done_timeout: got no done want done after %0d bursts", nm, nb);
    end
    @(negedge clk);
    total++;
    if (ctrl_done !== 1'b0) begin
      bad++; $display("FAIL %s done_pulse: got %b want 0 one cycle later", nm, ctrl_done);
    end
  endtask

  task automatic test_credit();
    int  n_aw, n_b, pending;
    bit  saw_done;
    n_aw = 0; n_b = 0;
    m_axi_bvalid = 1'b0;
    kick(64'h0, 32'd81920);
    for (int c = 0; c < 40; c++) begin
      m_axi_awready = 1'b1;
      #1;
      if (m_axi_awvalid) n_aw++;
      @(negedge clk);
    end
    total++;
    if (n_aw != 16 || m_axi_awvalid !== 1'b0) begin
      bad++; $display("FAIL credit_stall: got aw=%0d awv=%b want aw=16 awv=0", n_aw, m_axi_awvalid);
    end
    m_axi_awready = 1'b0;
    m_axi_bvalid  = 1'b1;
    m_axi_bresp   = 2'b00;
    @(negedge clk);
    m_axi_bvalid = 1'b0;
    n_b = 1;
    total++;
    if (m_axi_awvalid !== 1'b1) begin
      bad++; $display("FAIL credit_release: got awv=%b want 1 the cycle after one B", m_axi_awvalid);
    end
    pending = 15;
    run_out(pending, n_aw, n_b, saw_done);
    total++;
    if (!saw_done || n_aw != 20 || n_b != 20) begin
      bad++; $display("FAIL credit_done: got done=%b aw=%0d b=%0d want done=1 aw=20 b=20", saw_done, n_aw, n_b);
    end
    @(negedge clk);
  endtask

  task automatic test_stable();
    int  n_aw, n_b, pending;
    bit  saw_done;
    m_axi_awready = 1'b0; m_axi_bvalid = 1'b0;
    kick(64'h10000, 32'd12288);
    for (int c = 0; c < 10 && m_axi_awvalid !== 1'b1; c++) @(negedge clk);
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 64'h11000 || m_axi_awlen !== 8'd63) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b a=%h l=%0d want v=1 a=11000 l=63", c, m_axi_awvalid, m_axi_awaddr, m_axi_awlen);
      end
      @(negedge clk);
    end
    m_axi_awready = 1'b1;
    m_axi_bvalid  = 1'b1;
    m_axi_bresp   = 2'b00;
    @(negedge clk);
    m_axi_awready = 1'b0;
    m_axi_bvalid  = 1'b0;
    total++;
    if (dut.r_outstanding !== 5'd1) begin
      bad++; $display("FAIL same_cycle_aw_b: got outstanding=%0d want 1", dut.r_outstanding);
    end
    n_aw = 2; n_b = 1; pending = 1;
    run_out(pending, n_aw, n_b, saw_done);
    total++;
    if (!saw_done || n_aw != 3 || n_b != 3) begin
      bad++; $display("FAIL stable_done: got done=%b aw=%0d b=%0d want done=1 aw=3 b=3", saw_done, n_aw, n_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_drain();
    bit early_done;
    m_axi_bvalid = 1'b0;
    kick(64'h40000, 32'd12288);
    m_axi_awready = 1'b1;
    repeat (10) @(negedge clk);
    m_axi_awready = 1'b0;
    total++;
    if (dut.r_outstanding !== 5'd3 || m_axi_awvalid !== 1'b0) begin
      bad++; $display("FAIL drain_setup: got outstanding=%0d awv=%b want 3 and 0", dut.r_outstanding, m_axi_awvalid);
    end
    rst = 1'b1;
    m_axi_bvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({ctrl_done, ctrl_err, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_bready,
         wburst_push, wburst_len} !== '0 || dut.r_outstanding !== 5'd0) begin
      bad++; $display("FAIL rst_in_drain: got done=%b awv=%b bready=%b awaddr=%h outst=%0d want all 0",
                      ctrl_done, m_axi_awvalid, m_axi_bready, m_axi_awaddr, dut.r_outstanding);
    end
    rst = 1'b0;
    early_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ctrl_done || m_axi_bready || dut.r_outstanding != 0) early_done = 1'b1;
    end
    m_axi_bvalid = 1'b0;
    total++;
    if (early_done) begin
      bad++; $display("FAIL late_b_ignored: got done/bready/outstanding activity=1 want 0");
    end
    test_xfer("post_rst", 64'h40000, 32'd64, 100, 100, -1, -1);
  endtask

  task automatic test_random();
    logic [31:0] sizes[8];
    sizes = '{32'd1, 32'd63, 32'd64, 32'd65, 32'd4096, 32'd4097, 32'd4159, 32'd0};
    foreach (sizes[i])
      test_xfer("edge", {$urandom, $urandom}, sizes[i], 100, 100, -1, -1);
    for (int t = 0; t < 12; t++)
      test_xfer("rand", {$urandom, $urandom}, 32'($urandom_range(70000)),
                $urandom_range(100, 30), $urandom_range(100, 20), -1, -1);
  endtask

  initial begin
    test_reset();
    test_xfer("basic_8k", 64'h1000, 32'd8192, 100, 100, -1, -1);
    test_xfer("size100", 64'h2040, 32'd100, 100, 100, -1, -1);
    test_xfer("size0", 64'h3000, 32'd0, 100, 100, -1, -1);
    test_credit();
    test_stable();
    test_xfer("bresp_err", 64'h8000, 32'd12288, 100, 100, 1, 0);
    test_xfer("err_clear", 64'h9000, 32'd4096, 100, 100, -1, -1);
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
